// File: rtl/uart_core_param.sv
// Full-duplex UART with configurable frame format, a shared fractional baud
// generator, valid/ready handshakes and parity/framing/break/overrun status.
module uart_core_param #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd,
    input  logic                 rxd,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_break,
    output logic                 rx_overrun
);

    localparam logic [63:0] INC_L = (64'(BAUD) * 64'(OVERSAMPLE) * 64'd65536
                                     + 64'(CLK_FREQ / 2)) / 64'(CLK_FREQ);
    localparam logic [15:0] INC = INC_L[15:0];

    localparam int CW = $clog2(STOP_BITS * OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_END = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (INC_L == 64'd0 || INC_L >= 64'd65536) begin : g_bad_inc
        $error("uart_core_param: baud increment out of range");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
        $error("uart_core_param: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_core_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_core_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_os
        $error("uart_core_param: OVERSAMPLE must be 8 or 16");
    end

    // Fractional baud generator: tick is the carry out of the phase accumulator.
    logic [15:0] acc_q;
    logic [16:0] acc_sum;
    logic        tick;

    assign acc_sum = {1'b0, acc_q} + {1'b0, INC};
    assign tick    = acc_sum[16];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_sum[15:0];
    end

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shreg_q, tx_shreg_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_d;

    assign tx_ready = (tx_state_q == TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shreg_q <= '0;
            tx_par_q   <= 1'b0;
            txd        <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shreg_q <= tx_shreg_d;
            tx_par_q   <= tx_par_d;
            txd        <= txd_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shreg_d = tx_shreg_q;
        tx_par_d   = tx_par_q;
        txd_d      = 1'b1;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid) begin
                    tx_state_d = TX_START;
                    tx_shreg_d = tx_data;
                    tx_cnt_d   = '0;
                    tx_par_d   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_d   = '0;
                        tx_bit_d   = '0;
                        tx_state_d = TX_DATA;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_d   = '0;
                        tx_shreg_d = {1'b0, tx_shreg_q[DATA_BITS-1:1]};
                        if (tx_bit_q == LAST_BIT)
                            tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
                        else
                            tx_bit_d = tx_bit_q + BW'(1);
                    end else begin
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tick) begin
                    if (tx_cnt_q == BIT_END) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_cnt_d = tx_cnt_q + CW'(1);
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    if (tx_cnt_q == STOP_END) tx_state_d = TX_IDLE;
                    else                      tx_cnt_d   = tx_cnt_q + CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // Line level is registered from the next state so it changes with the state.
        unique case (tx_state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = tx_shreg_d[0];
            TX_PARITY: txd_d = tx_par_d;
            default:   txd_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;

    logic [1:0]           sync_q;
    logic                 rxs;
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shreg_q, rx_shreg_d;
    logic                 rx_par_q, rx_par_d;
    logic                 done_q, done_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 brk_q, brk_d;
    logic                 exp_par;

    assign rxs     = sync_q[1];
    assign exp_par = (PARITY == 1) ? ~^rx_shreg_q : ^rx_shreg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shreg_q <= '0;
            rx_par_q   <= 1'b0;
            done_q     <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], rxd};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shreg_q <= rx_shreg_d;
            rx_par_q   <= rx_par_d;
            done_q     <= done_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            brk_q      <= brk_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shreg_d = rx_shreg_q;
        rx_par_d   = rx_par_q;
        done_d     = 1'b0;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        brk_d      = brk_q;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (tick && !rxs) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_cnt_q == HALF_END) begin
                        rx_cnt_d   = '0;
                        rx_bit_d   = '0;
                        rx_state_d = rxs ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_d   = '0;
                        rx_shreg_d = {rxs, rx_shreg_q[DATA_BITS-1:1]};
                        if (rx_bit_q == LAST_BIT)
                            rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
                        else
                            rx_bit_d = rx_bit_q + BW'(1);
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (tick) begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_cnt_d   = '0;
                        rx_par_d   = rxs;
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    if (rx_cnt_q == BIT_END) begin
                        rx_state_d = RX_IDLE;
                        done_d     = 1'b1;
                        ferr_d     = !rxs;
                        perr_d     = (PARITY != 0) && (rx_par_q != exp_par);
                        brk_d      = !rxs && (rx_shreg_q == '0) && (PARITY == 0 || !rx_par_q);
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Single-entry output register; a frame that finds it occupied is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid      <= 1'b0;
            rx_data       <= '0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_break      <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (done_q) begin
                if (!rx_valid || rx_ready) begin
                    rx_valid      <= 1'b1;
                    rx_data       <= rx_shreg_q;
                    rx_parity_err <= perr_q;
                    rx_frame_err  <= ferr_q;
                    rx_break      <= brk_q;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
